// File: rtl/if_fetch_unit_if.sv
// Bus bundle between the instruction-fetch stage and its environment.
// Optional member o_fetch_count exists only when FETCH_COUNT_EN is defined.
interface if_fetch_unit_if #(
    parameter int unsigned NB_PC     = 32,
    parameter int unsigned NB_INSTR  = 32,
    parameter int unsigned NB_OPCODE = 6,
    parameter int unsigned NB_ADDR   = 6
);
    logic                 i_load_we;
    logic [NB_ADDR-1:0]   i_load_addr;
    logic [NB_INSTR-1:0]  i_load_data;
    logic                 i_start;
    logic                 i_stall;
    logic                 i_flush;
    logic                 i_branch_taken;
    logic [NB_PC-1:0]     i_branch_target;
    logic [NB_INSTR-1:0]  o_instruction;
    logic [NB_OPCODE-1:0] o_opcode;
    logic [NB_PC-1:0]     o_pc_plus4;
    logic [NB_PC-1:0]     o_pc;
    logic                 o_valid;
    logic                 o_halted;
`ifdef FETCH_COUNT_EN
    logic [31:0]          o_fetch_count;
`endif

    // Environment side: drives loads/control, observes the IF/ID register.
    modport master (
        output i_load_we, i_load_addr, i_load_data, i_start, i_stall,
        output i_flush, i_branch_taken, i_branch_target,
        input  o_instruction, o_opcode, o_pc_plus4, o_pc, o_valid, o_halted
`ifdef FETCH_COUNT_EN
        , input o_fetch_count
`endif
    );

    // Fetch-stage side.
    modport slave (
        input  i_load_we, i_load_addr, i_load_data, i_start, i_stall,
        input  i_flush, i_branch_taken, i_branch_target,
        output o_instruction, o_opcode, o_pc_plus4, o_pc, o_valid, o_halted
`ifdef FETCH_COUNT_EN
        , output o_fetch_count
`endif
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, load-port instruction memory, IF/ID register
// and a run/halt FSM. Define FETCH_COUNT_EN to add a saturating count of
// valid fetches on o_fetch_count.
module if_fetch_unit #(
    parameter int unsigned         NB_PC     = 32,
    parameter int unsigned         NB_INSTR  = 32,
    parameter int unsigned         NB_OPCODE = 6,
    parameter int unsigned         NB_ADDR   = 6,
    parameter logic [NB_INSTR-1:0] HALT_WORD = '1
) (
    input  logic                i_clock,
    input  logic                i_reset,
    if_fetch_unit_if.slave      bus
);
    localparam int unsigned MEM_DEPTH = 2 ** NB_ADDR;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t              state_q, state_n;
    logic [NB_PC-1:0]    pc_q, pc_n;
    logic [NB_INSTR-1:0] instr_q, instr_n;
    logic [NB_PC-1:0]    pc_plus4_q, pc_plus4_n;
    logic                valid_q, valid_n;
    logic                fetch_c;

    logic [NB_INSTR-1:0] mem [MEM_DEPTH];
    logic [NB_INSTR-1:0] mem_rd_c;
    logic [NB_PC-1:0]    pc_inc_c;

    assign mem_rd_c = mem[pc_q[NB_ADDR+1:2]];
    assign pc_inc_c = pc_q + NB_PC'(4);

    // Load-port writes, accepted only while not running; never reset.
    always_ff @(posedge i_clock) begin
        if (bus.i_load_we && (state_q != ST_RUN)) begin
            mem[bus.i_load_addr] <= bus.i_load_data;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next state and next PC / IF/ID contents, by priority branch > flush > stall.
    always_comb begin
        state_n    = state_q;
        pc_n       = pc_q;
        instr_n    = instr_q;
        pc_plus4_n = pc_plus4_q;
        valid_n    = valid_q;
        fetch_c    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                pc_n       = '0;
                instr_n    = '0;
                pc_plus4_n = '0;
                valid_n    = 1'b0;
                if (bus.i_start) begin
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.i_branch_taken) begin
                    pc_n       = bus.i_branch_target & ~NB_PC'(3);
                    instr_n    = '0;
                    pc_plus4_n = '0;
                    valid_n    = 1'b0;
                end else if (bus.i_flush) begin
                    instr_n    = '0;
                    pc_plus4_n = '0;
                    valid_n    = 1'b0;
                end else if (!bus.i_stall) begin
                    fetch_c    = 1'b1;
                    instr_n    = mem_rd_c;
                    pc_plus4_n = pc_inc_c;
                    valid_n    = 1'b1;
                    pc_n       = pc_inc_c;
                    if (mem_rd_c == HALT_WORD) begin
                        state_n = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                instr_n    = '0;
                pc_plus4_n = '0;
                valid_n    = 1'b0;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // PC and IF/ID pipeline register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            pc_q       <= '0;
            instr_q    <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_n;
            instr_q    <= instr_n;
            pc_plus4_q <= pc_plus4_n;
            valid_q    <= valid_n;
        end
    end

`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count_q;

    // Saturating count of edges that load a valid instruction into IF/ID.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            fetch_count_q <= '0;
        end else if (fetch_c && (fetch_count_q != '1)) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign bus.o_fetch_count = fetch_count_q;
`endif

    assign bus.o_instruction = instr_q;
    assign bus.o_opcode      = instr_q[NB_INSTR-1 -: NB_OPCODE];
    assign bus.o_pc_plus4    = pc_plus4_q;
    assign bus.o_pc          = pc_q;
    assign bus.o_valid       = valid_q;
    assign bus.o_halted      = (state_q == ST_HALT);
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: run/halt, stall, flush, branch, reset, wrap.
module tb_if_fetch_unit;
    localparam logic [31:0] M0  = 32'h20010005;
    localparam logic [31:0] M1  = 32'h20020007;
    localparam logic [31:0] M2  = 32'h00221820;
    localparam logic [31:0] M3  = 32'hFFFFFFFF;
    localparam logic [31:0] M4  = 32'h8C240000;
    localparam logic [31:0] M5  = 32'h00000020;
    localparam logic [31:0] M63 = 32'hAC01003F;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    if_fetch_unit_if #(.NB_PC(32), .NB_INSTR(32), .NB_OPCODE(6), .NB_ADDR(6)) bus ();

    if_fetch_unit #(
        .NB_PC(32), .NB_INSTR(32), .NB_OPCODE(6), .NB_ADDR(6), .HALT_WORD(32'hFFFFFFFF)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required $finish)");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [5:0] addr, input logic [31:0] data);
        bus.i_load_we   = 1'b1;
        bus.i_load_addr = addr;
        bus.i_load_data = data;
        tick();
        bus.i_load_we   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
    endtask

    task automatic check_fetch(input string tag, input logic [31:0] instr,
                               input logic [31:0] pc4);
        check_eq({tag, "_instr"}, bus.o_instruction, instr);
        check_eq({tag, "_valid"}, 32'(bus.o_valid), 32'd1);
        check_eq({tag, "_pc4"},   bus.o_pc_plus4, pc4);
        check_eq({tag, "_pc"},    bus.o_pc, pc4);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst                 = 1'b1;
        bus.i_load_we       = 1'b0;
        bus.i_load_addr     = '0;
        bus.i_load_data     = '0;
        bus.i_start         = 1'b0;
        bus.i_stall         = 1'b0;
        bus.i_flush         = 1'b0;
        bus.i_branch_taken  = 1'b0;
        bus.i_branch_target = '0;
        tick();
        tick();
        rst = 1'b0;

        // Program load in IDLE, then reset: memory must survive.
        load_word(6'd0, M0);
        load_word(6'd1, M1);
        load_word(6'd2, M2);
        load_word(6'd3, M3);
        load_word(6'd4, M4);
        load_word(6'd5, M5);
        load_word(6'd63, M63);
        do_reset();
        check_eq("rst_instr",  bus.o_instruction, 32'h0);
        check_eq("rst_pc",     bus.o_pc, 32'h0);
        check_eq("rst_pc4",    bus.o_pc_plus4, 32'h0);
        check_eq("rst_valid",  32'(bus.o_valid), 32'd0);
        check_eq("rst_halted", 32'(bus.o_halted), 32'd0);

        // Control inputs ignored in IDLE.
        bus.i_branch_taken  = 1'b1;
        bus.i_branch_target = 32'h40;
        tick();
        bus.i_branch_taken  = 1'b0;
        check_eq("idle_br_pc",    bus.o_pc, 32'h0);
        check_eq("idle_br_valid", 32'(bus.o_valid), 32'd0);

        // T1: run to halt.
        pulse_start();
        check_eq("t1_run_pc",    bus.o_pc, 32'h0);
        check_eq("t1_run_valid", 32'(bus.o_valid), 32'd0);
        tick();
        check_fetch("t1_f0", M0, 32'h4);
        check_eq("t1_f0_opc", 32'(bus.o_opcode), 32'h08);
        tick();
        check_fetch("t1_f1", M1, 32'h8);
        tick();
        check_fetch("t1_f2", M2, 32'hC);
        check_eq("t1_f2_halted", 32'(bus.o_halted), 32'd0);
        tick();
        check_fetch("t1_f3", M3, 32'h10);
        check_eq("t1_halted", 32'(bus.o_halted), 32'd1);
`ifdef FETCH_COUNT_EN
        check_eq("t1_count", bus.o_fetch_count, 32'd4);
`endif
        tick();
        check_eq("t1_post_valid", 32'(bus.o_valid), 32'd0);
        check_eq("t1_post_instr", bus.o_instruction, 32'h0);
        check_eq("t1_post_pc",    bus.o_pc, 32'h10);
        pulse_start();
        tick();
        check_eq("t1_start_ign_pc",  bus.o_pc, 32'h10);
        check_eq("t1_start_ign_hlt", 32'(bus.o_halted), 32'd1);

        // T2: 2-cycle stall at pc 0x8, then stall/flush on the halt-fetch cycle.
        do_reset();
        pulse_start();
        tick();
        tick();
        check_fetch("t2_pre", M1, 32'h8);
        bus.i_stall = 1'b1;
        tick();
        check_eq("t2_s1_pc",    bus.o_pc, 32'h8);
        check_eq("t2_s1_instr", bus.o_instruction, M1);
        tick();
        check_eq("t2_s2_pc",    bus.o_pc, 32'h8);
        check_eq("t2_s2_instr", bus.o_instruction, M1);
        bus.i_stall = 1'b0;
        tick();
        check_fetch("t2_rel", M2, 32'hC);
        bus.i_stall = 1'b1;
        tick();
        check_eq("t2_hstall_halted", 32'(bus.o_halted), 32'd0);
        check_eq("t2_hstall_pc",     bus.o_pc, 32'hC);
        check_eq("t2_hstall_valid",  32'(bus.o_valid), 32'd1);
        bus.i_stall = 1'b0;
        bus.i_flush = 1'b1;
        tick();
        check_eq("t2_hflush_halted", 32'(bus.o_halted), 32'd0);
        check_eq("t2_hflush_valid",  32'(bus.o_valid), 32'd0);
        check_eq("t2_hflush_pc",     bus.o_pc, 32'hC);
        bus.i_flush = 1'b0;
        tick();
        check_fetch("t2_halt", M3, 32'h10);
        check_eq("t2_halted", 32'(bus.o_halted), 32'd1);
`ifdef FETCH_COUNT_EN
        check_eq("t2_count", bus.o_fetch_count, 32'd4);
`endif
        bus.i_branch_taken  = 1'b1;
        bus.i_branch_target = 32'h0;
        tick();
        bus.i_branch_taken  = 1'b0;
        check_eq("t2_halt_br_pc", bus.o_pc, 32'h10);

        // T3: branch with unaligned target; load attempt in RUN is ignored; flush.
        do_reset();
        pulse_start();
        tick();
        tick();
        check_eq("t3_pre_pc", bus.o_pc, 32'h8);
        bus.i_branch_taken  = 1'b1;
        bus.i_branch_target = 32'h13;
        bus.i_load_we       = 1'b1;
        bus.i_load_addr     = 6'd4;
        bus.i_load_data     = 32'hDEADBEEF;
        tick();
        bus.i_branch_taken  = 1'b0;
        bus.i_load_we       = 1'b0;
        check_eq("t3_br_valid", 32'(bus.o_valid), 32'd0);
        check_eq("t3_br_opc",   32'(bus.o_opcode), 32'h0);
        check_eq("t3_br_pc",    bus.o_pc, 32'h10);
        tick();
        check_fetch("t3_tgt", M4, 32'h14);
        check_eq("t3_tgt_opc", 32'(bus.o_opcode), 32'h23);
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        check_eq("t3_fl_valid", 32'(bus.o_valid), 32'd0);
        check_eq("t3_fl_instr", bus.o_instruction, 32'h0);
        check_eq("t3_fl_pc",    bus.o_pc, 32'h14);
        tick();
        check_fetch("t3_after_fl", M5, 32'h18);

        // T4: reset mid-run, then restart from mem[0].
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t4_instr",  bus.o_instruction, 32'h0);
        check_eq("t4_pc",     bus.o_pc, 32'h0);
        check_eq("t4_pc4",    bus.o_pc_plus4, 32'h0);
        check_eq("t4_valid",  32'(bus.o_valid), 32'd0);
        check_eq("t4_halted", 32'(bus.o_halted), 32'd0);
        pulse_start();
        tick();
        check_fetch("t4_refetch", M0, 32'h4);

        // T5: memory-index wrap at 0x100 and PC wrap at 2**32.
        do_reset();
        pulse_start();
        bus.i_branch_taken  = 1'b1;
        bus.i_branch_target = 32'hFC;
        tick();
        bus.i_branch_taken  = 1'b0;
        check_eq("t5_br_pc", bus.o_pc, 32'hFC);
        tick();
        check_fetch("t5_m63", M63, 32'h100);
        check_eq("t5_m63_opc", 32'(bus.o_opcode), 32'h2B);
        tick();
        check_fetch("t5_alias", M0, 32'h104);
        bus.i_branch_taken  = 1'b1;
        bus.i_branch_target = 32'hFFFFFFFF;
        tick();
        bus.i_branch_taken  = 1'b0;
        check_eq("t5_top_pc", bus.o_pc, 32'hFFFFFFFC);
        tick();
        check_fetch("t5_pcwrap", M63, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
